// File: rtl/mem_rd_arbiter.sv
// Two-master AXI read-address/read-data arbiter in front of a single DRAM port.
// One burst is outstanding at a time; ties are broken round-robin and the
// granted master's R channel is a zero-latency pass-through of the slave's.
module mem_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_done,
    // m0 = CPU
    input  logic              i_m0_arvalid,
    output logic              o_m0_arready,
    input  logic [ADDR_W-1:0] i_m0_araddr,
    input  logic [7:0]        i_m0_arlen,
    input  logic [2:0]        i_m0_arsize,
    input  logic [1:0]        i_m0_arburst,
    input  logic [ID_W-1:0]   i_m0_arid,
    output logic              o_m0_rvalid,
    input  logic              i_m0_rready,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic [1:0]        o_m0_rresp,
    output logic              o_m0_rlast,
    output logic [ID_W-1:0]   o_m0_rid,
    // m1 = VGA fetch
    input  logic              i_m1_arvalid,
    output logic              o_m1_arready,
    input  logic [ADDR_W-1:0] i_m1_araddr,
    input  logic [7:0]        i_m1_arlen,
    input  logic [2:0]        i_m1_arsize,
    input  logic [1:0]        i_m1_arburst,
    input  logic [ID_W-1:0]   i_m1_arid,
    output logic              o_m1_rvalid,
    input  logic              i_m1_rready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [1:0]        o_m1_rresp,
    output logic              o_m1_rlast,
    output logic [ID_W-1:0]   o_m1_rid,
    // slave side toward CDC / DRAM
    output logic              o_s_arvalid,
    input  logic              i_s_arready,
    output logic [ADDR_W-1:0] o_s_araddr,
    output logic [7:0]        o_s_arlen,
    output logic [2:0]        o_s_arsize,
    output logic [1:0]        o_s_arburst,
    output logic [ID_W-1:0]   o_s_arid,
    input  logic              i_s_rvalid,
    output logic              o_s_rready,
    input  logic [DATA_W-1:0] i_s_rdata,
    input  logic [1:0]        i_s_rresp,
    input  logic              i_s_rlast,
    input  logic [ID_W-1:0]   i_s_rid,
    // status
    output logic              o_busy,
    output logic              o_err,
    output logic              o_grant
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic win;        // candidate winner in IDLE: 0 = m0, 1 = m1
    logic ar_hs;      // master AR handshake this cycle
    logic in_data;
    logic sel_rready; // rready of the granted master
    logic r_hs;       // R handshake on the slave side

    // Winner selection and the combinational arready that goes with it.
    always_comb begin
        win          = (i_m0_arvalid && i_m1_arvalid) ? ~last_grant_q : i_m1_arvalid;
        o_m0_arready = !i_rst && (state_q == S_IDLE) && i_init_done && i_m0_arvalid && !win;
        o_m1_arready = !i_rst && (state_q == S_IDLE) && i_init_done && i_m1_arvalid &&  win;
        ar_hs        = o_m0_arready || o_m1_arready;
    end

    // R channel routing: slave beats go straight to the granted master.
    always_comb begin
        in_data     = (state_q == S_DATA);
        sel_rready  = grant_q ? i_m1_rready : i_m0_rready;
        o_s_rready  = in_data && sel_rready;
        r_hs        = in_data && i_s_rvalid && sel_rready;
        o_m0_rvalid = in_data && !grant_q && i_s_rvalid;
        o_m0_rlast  = in_data && !grant_q && i_s_rlast;
        o_m1_rvalid = in_data &&  grant_q && i_s_rvalid;
        o_m1_rlast  = in_data &&  grant_q && i_s_rlast;
        o_m0_rdata  = i_s_rdata;
        o_m0_rresp  = i_s_rresp;
        o_m0_rid    = i_s_rid;
        o_m1_rdata  = i_s_rdata;
        o_m1_rresp  = i_s_rresp;
        o_m1_rid    = i_s_rid;
    end

    // Next-state logic: grant capture, address phase, beat counting and error check.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    state_d = S_ADDR;
                    grant_d = win;
                    addr_d  = win ? i_m1_araddr  : i_m0_araddr;
                    len_d   = win ? i_m1_arlen   : i_m0_arlen;
                    size_d  = win ? i_m1_arsize  : i_m0_arsize;
                    burst_d = win ? i_m1_arburst : i_m0_arburst;
                    id_d    = win ? i_m1_arid    : i_m0_arid;
                end
            end
            S_ADDR: begin
                if (i_s_arready) begin
                    state_d = S_DATA;
                    cnt_d   = 8'd0;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    if (i_s_rlast) begin
                        // rlast alone ends the burst; a length mismatch is only flagged.
                        if (cnt_q != len_q) err_d = 1'b1;
                        state_d      = S_IDLE;
                        last_grant_d = grant_q;
                        cnt_d        = 8'd0;
                    end else begin
                        if (cnt_q == len_q) err_d = 1'b1;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign o_s_arvalid = (state_q == S_ADDR);
    assign o_s_araddr  = addr_q;
    assign o_s_arlen   = len_q;
    assign o_s_arsize  = size_q;
    assign o_s_arburst = burst_q;
    assign o_s_arid    = id_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_err       = err_q;
    assign o_grant     = grant_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: bench-side masters and DRAM slave,
// a transaction-level expectation queue, and a negedge monitor that compares.
module tb_mem_rd_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  id;
    } ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [5:0]  id;
        logic        last;
    } r_t;

    logic        clk = 1'b0;
    logic        rst, init_done;
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic [5:0]  m0_arid, m1_arid;
    logic        s_arready, s_rvalid, s_rlast;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [5:0]  s_rid;

    logic        o_m0_arready, o_m1_arready, o_m0_rvalid, o_m1_rvalid;
    logic        o_m0_rlast, o_m1_rlast;
    logic [63:0] o_m0_rdata, o_m1_rdata;
    logic [1:0]  o_m0_rresp, o_m1_rresp;
    logic [5:0]  o_m0_rid, o_m1_rid;
    logic        o_s_arvalid, o_s_rready;
    logic [31:0] o_s_araddr;
    logic [7:0]  o_s_arlen;
    logic [2:0]  o_s_arsize;
    logic [1:0]  o_s_arburst;
    logic [5:0]  o_s_arid;
    logic        o_busy, o_err, o_grant;

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
        .i_m0_arvalid(m0_arvalid), .o_m0_arready(o_m0_arready), .i_m0_araddr(m0_araddr),
        .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
        .i_m0_arid(m0_arid), .o_m0_rvalid(o_m0_rvalid), .i_m0_rready(m0_rready),
        .o_m0_rdata(o_m0_rdata), .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast),
        .o_m0_rid(o_m0_rid),
        .i_m1_arvalid(m1_arvalid), .o_m1_arready(o_m1_arready), .i_m1_araddr(m1_araddr),
        .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
        .i_m1_arid(m1_arid), .o_m1_rvalid(o_m1_rvalid), .i_m1_rready(m1_rready),
        .o_m1_rdata(o_m1_rdata), .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast),
        .o_m1_rid(o_m1_rid),
        .o_s_arvalid(o_s_arvalid), .i_s_arready(s_arready), .o_s_araddr(o_s_araddr),
        .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst),
        .o_s_arid(o_s_arid), .i_s_rvalid(s_rvalid), .o_s_rready(o_s_rready),
        .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast), .i_s_rid(s_rid),
        .o_busy(o_busy), .o_err(o_err), .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL timeout %s t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave payload is a pure function of address and beat number.
    function automatic logic [63:0] data_fn(input logic [31:0] a, input int b);
        logic [31:0] k;
        k = 32'(b) * 32'h9E37_79B9;
        return {a, a ^ k};
    endfunction

    function automatic logic [1:0] resp_fn(input logic [31:0] a, input int b);
        logic [31:0] bb;
        bb = 32'(b);
        return a[1:0] ^ bb[1:0];
    endfunction

    // ---------------- expectations ----------------
    ar_t ar_exp[$];
    r_t  r_exp0[$];
    r_t  r_exp1[$];
    bit  grant_log[$];

    // ---------------- knobs ----------------
    int rr_mode     = 0;  // 0: rready=1, 1: random, 2: toggle 1010...
    int sl_ar_delay = -1; // -1: random 0..3 cycles of s_arready=0
    int sl_early    = -1; // >=0: slave asserts rlast on this beat index
    bit mon_en      = 0;

    // Master R-ready generators.
    initial begin
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        forever begin
            tick();
            case (rr_mode)
                1: begin m0_rready = 1'($urandom_range(0, 1)); m1_rready = 1'($urandom_range(0, 1)); end
                2: begin m0_rready = ~m0_rready; m1_rready = ~m1_rready; end
                default: begin m0_rready = 1'b1; m1_rready = 1'b1; end
            endcase
        end
    end

    // Issue one read request from master m and record what it should produce.
    task automatic master_req(input int m, input ar_t ar, input int exp_beats);
        bit done = 0;
        if (m == 0) begin
            m0_araddr = ar.addr; m0_arlen = ar.len; m0_arsize = ar.size;
            m0_arburst = ar.burst; m0_arid = ar.id; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = ar.addr; m1_arlen = ar.len; m1_arsize = ar.size;
            m1_arburst = ar.burst; m1_arid = ar.id; m1_arvalid = 1'b1;
        end
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if ((m == 0) ? o_m0_arready : o_m1_arready) begin
                ar_exp.push_back(ar);
                for (int b = 0; b < exp_beats; b++) begin
                    r_t r;
                    r.data = data_fn(ar.addr, b);
                    r.resp = resp_fn(ar.addr, b);
                    r.id   = ar.id;
                    r.last = (b == exp_beats - 1);
                    if (m == 0) r_exp0.push_back(r);
                    else        r_exp1.push_back(r);
                end
                done = 1;
            end
        end
        if (!done) timeout_fail("master_ar_handshake");
        tick();
        if (m == 0) m0_arvalid = 1'b0;
        else        m1_arvalid = 1'b0;
    endtask

    function automatic ar_t rand_ar(input int max_len);
        ar_t a;
        a.addr  = $urandom;
        a.len   = 8'($urandom_range(0, max_len));
        a.size  = 3'($urandom_range(0, 7));
        a.burst = 2'($urandom_range(0, 2));
        a.id    = 6'($urandom_range(0, 63));
        return a;
    endfunction

    // Slave: accept one AR, possibly after a delay.
    task automatic slave_ar(output ar_t ar);
        bit seen = 0;
        int d;
        ar = '0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            seen = o_s_arvalid;
        end
        if (!seen) begin
            timeout_fail("slave_arvalid");
            return;
        end
        tick();
        d = (sl_ar_delay >= 0) ? sl_ar_delay : $urandom_range(0, 3);
        repeat (d) tick();
        s_arready = 1'b1;
        @(negedge clk);
        ar = '{addr: o_s_araddr, len: o_s_arlen, size: o_s_arsize, burst: o_s_arburst, id: o_s_arid};
        tick();
        s_arready = 1'b0;
    endtask

    // Slave: present one R beat and hold it until accepted.
    task automatic slave_beat(input ar_t ar, input int b, input bit last, input bit gaps);
        bit done = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        s_rvalid = 1'b1;
        s_rdata  = data_fn(ar.addr, b);
        s_rresp  = resp_fn(ar.addr, b);
        s_rid    = ar.id;
        s_rlast  = last;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            done = o_s_rready;
        end
        if (!done) timeout_fail("slave_rready");
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    task automatic slave_serve(input int n);
        for (int i = 0; i < n; i++) begin
            ar_t ar;
            int  nb;
            slave_ar(ar);
            nb = (sl_early >= 0) ? sl_early + 1 : int'(ar.len) + 1;
            for (int b = 0; b < nb; b++) slave_beat(ar, b, b == nb - 1, 1'b1);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    bit          outstanding = 0;  // a burst has been granted and not yet ended
    bit          in_data     = 0;  // slave AR accepted, beats flowing
    bit          cur_grant   = 0;
    bit          last_w      = 1;
    bit          exp_err     = 0;
    bit          lat_chk     = 0;
    bit          hold_chk    = 0;
    int          beat_idx    = 0;
    int          cur_len     = 0;
    ar_t         prev_ar;

    always @(negedge clk) begin
        if (mon_en) begin
            bit  exp_any, exp_w, granted_rready;
            ar_t cur_ar;
            r_t  e;
            cur_ar = '{addr: o_s_araddr, len: o_s_arlen, size: o_s_arsize, burst: o_s_arburst, id: o_s_arid};

            check("err_flag", o_err, exp_err);
            check("busy", o_busy, outstanding);
            if (outstanding) check("grant", o_grant, cur_grant);

            if (lat_chk) check("s_arvalid_latency", o_s_arvalid, 1'b1);
            lat_chk = 0;

            if (hold_chk) begin
                check("s_arvalid_held", o_s_arvalid, 1'b1);
                check("s_ar_fields_stable", cur_ar, prev_ar);
            end
            hold_chk = o_s_arvalid && !s_arready;
            prev_ar  = cur_ar;

            // Arbitration model: one burst at a time, round-robin on ties.
            exp_any = init_done && !outstanding && (m0_arvalid || m1_arvalid);
            exp_w   = (m0_arvalid && m1_arvalid) ? !last_w : m1_arvalid;
            check("arready_any", o_m0_arready || o_m1_arready, exp_any);
            if (exp_any) begin
                check("winner_m1_arready", o_m1_arready, exp_w);
                check("winner_m0_arready", o_m0_arready, !exp_w);
            end
            if ((o_m0_arready && m0_arvalid) || (o_m1_arready && m1_arvalid)) begin
                cur_grant   = o_m1_arready;
                last_w      = o_m1_arready;
                cur_len     = o_m1_arready ? int'(m1_arlen) : int'(m0_arlen);
                outstanding = 1;
                beat_idx    = 0;
                lat_chk     = 1;
                grant_log.push_back(o_m1_arready);
            end

            if (o_s_arvalid && s_arready) begin
                if (ar_exp.size() == 0) timeout_fail("unexpected_slave_ar");
                else check("slave_ar_fields", cur_ar, ar_exp.pop_front());
                in_data = 1;
            end else if (in_data) begin
                granted_rready = cur_grant ? m1_rready : m0_rready;
                check("s_rready_mirror", o_s_rready, granted_rready);
                check("granted_rvalid", cur_grant ? o_m1_rvalid : o_m0_rvalid, s_rvalid);
                check("other_rvalid", cur_grant ? o_m0_rvalid : o_m1_rvalid, 1'b0);
                check("other_rlast", cur_grant ? o_m0_rlast : o_m1_rlast, 1'b0);
                if (s_rvalid && granted_rready) begin
                    if ((cur_grant ? r_exp1.size() : r_exp0.size()) == 0) timeout_fail("unexpected_r_beat");
                    else begin
                        e = cur_grant ? r_exp1.pop_front() : r_exp0.pop_front();
                        if (cur_grant)
                            check("m1_r_beat", {o_m1_rdata, o_m1_rresp, o_m1_rid, o_m1_rlast}, e);
                        else
                            check("m0_r_beat", {o_m0_rdata, o_m0_rresp, o_m0_rid, o_m0_rlast}, e);
                    end
                    if (s_rlast) begin
                        if (beat_idx != cur_len) exp_err = 1;
                        outstanding = 0;
                        in_data     = 0;
                    end else begin
                        if (beat_idx == cur_len) exp_err = 1;
                        if (beat_idx < 255) beat_idx++;
                    end
                end
            end else begin
                check("idle_m0_rvalid", o_m0_rvalid, 1'b0);
                check("idle_m1_rvalid", o_m1_rvalid, 1'b0);
            end
        end
    end

    task automatic check_queues_empty(input string tag);
        check({tag, "_ar_queue"}, ar_exp.size(), 0);
        check({tag, "_r0_queue"}, r_exp0.size(), 0);
        check({tag, "_r1_queue"}, r_exp1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        ar_t a0, a1;
        rst = 1'b1; init_done = 1'b1;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_araddr = 32'h1234; m0_arlen = 8'd3; m0_arsize = 3'd3; m0_arburst = 2'd1; m0_arid = 6'd5;
        m1_araddr = 32'h5678; m1_arlen = 8'd3; m1_arsize = 3'd3; m1_arburst = 2'd1; m1_arid = 6'd9;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;

        // Reset values with requests pending and init complete.
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_grant", o_grant, 1'b0);
        check("rst_s_arvalid", o_s_arvalid, 1'b0);
        check("rst_s_rready", o_s_rready, 1'b0);
        check("rst_m0_arready", o_m0_arready, 1'b0);
        check("rst_m1_arready", o_m1_arready, 1'b0);
        check("rst_m0_rvalid", o_m0_rvalid, 1'b0);
        check("rst_m1_rvalid", o_m1_rvalid, 1'b0);
        check("rst_s_ar_fields", {o_s_araddr, o_s_arlen, o_s_arsize, o_s_arburst, o_s_arid}, 0);

        tick();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; init_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1;

        // Init gating: no grant until init_done, then same-cycle arready.
        a0 = rand_ar(3);
        fork
            master_req(0, a0, int'(a0.len) + 1);
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("init_m0_arready", o_m0_arready, 1'b0);
                    check("init_s_arvalid", o_s_arvalid, 1'b0);
                end
                tick();
                init_done = 1'b1;
            end
            slave_serve(1);
        join
        repeat (2) tick();
        check_queues_empty("init");

        // Both masters continuously requesting len=3: grants alternate.
        grant_log.delete();
        fork
            for (int i = 0; i < 2; i++) begin a0 = rand_ar(0); a0.len = 8'd3; master_req(0, a0, 4); end
            for (int i = 0; i < 2; i++) begin a1 = rand_ar(0); a1.len = 8'd3; master_req(1, a1, 4); end
            slave_serve(4);
        join
        repeat (2) tick();
        check("rr_grant_count", grant_log.size(), 4);
        for (int i = 1; i < grant_log.size(); i++) check("rr_alternate", grant_log[i], !grant_log[i-1]);
        check_queues_empty("rr");

        // m1 granted, slave stalls s_arready for 5 cycles; m0 waits.
        sl_ar_delay = 5;
        fork
            begin a1 = rand_ar(3); master_req(1, a1, int'(a1.len) + 1); end
            begin tick(); tick(); a0 = rand_ar(3); master_req(0, a0, int'(a0.len) + 1); end
            slave_serve(2);
        join
        sl_ar_delay = -1;
        repeat (2) tick();
        check_queues_empty("stall");

        // Randomized traffic from both masters.
        rr_mode = 1;
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 4)) tick();
                a0 = rand_ar(15); master_req(0, a0, int'(a0.len) + 1);
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 4)) tick();
                a1 = rand_ar(15); master_req(1, a1, int'(a1.len) + 1);
            end
            slave_serve(40);
        join
        repeat (4) tick();
        check_queues_empty("random");
        check("random_no_err", o_err, 1'b0);

        // rready toggling 1010..., len=7.
        rr_mode = 2;
        fork
            begin a0 = rand_ar(0); a0.len = 8'd7; master_req(0, a0, 8); end
            slave_serve(1);
        join
        repeat (2) tick();
        check("toggle_no_err", o_err, 1'b0);
        check_queues_empty("toggle");

        // Slave ends a len=7 burst after 3 beats: sticky error, traffic continues.
        rr_mode = 0;
        sl_early = 2;
        fork
            begin a0 = rand_ar(0); a0.len = 8'd7; master_req(0, a0, 3); end
            slave_serve(1);
        join
        sl_early = -1;
        fork
            begin a1 = rand_ar(5); master_req(1, a1, int'(a1.len) + 1); end
            slave_serve(1);
        join
        repeat (2) tick();
        check("err_sticky", o_err, 1'b1);
        check_queues_empty("early_last");

        // Reset pulsed in the data phase after two beats.
        mon_en = 0;
        fork
            begin a0 = rand_ar(0); a0.len = 8'd7; master_req(0, a0, 8); end
            begin
                ar_t sa;
                slave_ar(sa);
                slave_beat(sa, 0, 1'b0, 1'b0);
                slave_beat(sa, 1, 1'b0, 1'b0);
            end
        join
        check("pre_rst_busy", o_busy, 1'b1);
        s_rvalid = 1'b1; s_rdata = 64'hDEAD; s_rlast = 1'b0;
        #1;
        check("pre_rst_m0_rvalid", o_m0_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_err", o_err, 1'b0);
        check("midrst_grant", o_grant, 1'b0);
        check("midrst_s_rready", o_s_rready, 1'b0);
        check("midrst_s_arvalid", o_s_arvalid, 1'b0);
        check("midrst_m0_rvalid", o_m0_rvalid, 1'b0);
        check("midrst_m1_rvalid", o_m1_rvalid, 1'b0);
        check("midrst_arready", {o_m0_arready, o_m1_arready}, 2'b00);
        s_rvalid = 1'b0;
        ar_exp.delete(); r_exp0.delete(); r_exp1.delete();
        tick(); tick();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tie_m0", o_m0_arready, 1'b1);
        check("post_rst_tie_m1", o_m1_arready, 1'b0);
        tick();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W=32 (AR address width), DATA_W=64 (R data width) and ID_W=6 (AR/R ID width).
REQ-002 i_clk  in  1  single clock (clk_core domain); all state SHALL be updated on the rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_init_done  in  1  DRAM init complete; while low, no grant is issued.
REQ-005 Per master x in {m0 = CPU, m1 = VGA fetch}:
 i_x_arvalid in 1; o_x_arready out 1; i_x_araddr in ADDR_W; i_x_arlen in 8; i_x_arsize in 3; i_x_arburst in 2; i_x_arid in ID_W.
REQ-006 Per master x: o_x_rvalid out 1; i_x_rready in 1; o_x_rdata out DATA_W; o_x_rresp out 2; o_x_rlast out 1; o_x_rid out ID_W.
REQ-007 Slave side (toward CDC/DRAM): o_s_arvalid, i_s_arready, o_s_araddr, o_s_arlen, o_s_arsize, o_s_arburst, o_s_arid, with the same widths as the master AR channel.
REQ-008 Slave side R channel: i_s_rvalid, o_s_rready, i_s_rdata, i_s_rresp, i_s_rlast, i_s_rid, with the same widths as the master R channel.
REQ-009 Status outputs: o_busy out 1 (state != IDLE); o_err out 1 (sticky burst-length mismatch); o_grant out 1 (0 = m0, 1 = m1, valid while busy).

Function
REQ-010 The arbiter SHALL have exactly one burst outstanding at a time, using states IDLE, ADDR and DATA.
REQ-011 IDLE, i_init_done low: o_x_arready SHALL be 0 for both masters and no state change SHALL occur.
REQ-012 IDLE, i_init_done high, exactly one arvalid: that master wins.
REQ-013 IDLE, both arvalid: the master not granted last wins (round-robin); last_grant resets to 1, so m0 wins the first tie.
REQ-014 In IDLE, o_x_arready SHALL be asserted combinationally for the winner only, in the same cycle as its arvalid.
REQ-015 On winner handshake, the arbiter SHALL capture addr/len/size/burst/id into registers, latch the grant and go to ADDR on the next cycle.
REQ-016 ADDR: o_s_arvalid=1 with the registered fields, held stable until i_s_arready; on the handshake, go to DATA.
REQ-017 The first o_s_arvalid SHALL occur exactly 1 cycle after the master AR handshake.
REQ-018 DATA: slave R signals SHALL pass combinationally to the granted master (zero latency), and o_s_rready SHALL equal the granted master's rready.
REQ-019 DATA: the non-granted master SHALL see o_rvalid=0 and o_rlast=0.
REQ-020 A beat counter SHALL clear on ADDR exit and increment on each R handshake.
REQ-021 On an R handshake with rlast=1, the arbiter SHALL return to IDLE, update last_grant to the current grant and clear the counter.
REQ-022 If rlast arrives with counter != arlen, or the counter reaches arlen without rlast, the arbiter SHALL set o_err (sticky until reset); burst completion is still governed by rlast only.
REQ-023 arlen=0 (single beat) SHALL be legal; counter arithmetic SHALL be 8-bit with no wrap beyond 255.
REQ-024 A request arriving while busy SHALL wait with arready=0; the master holds arvalid per AXI, and no request is dropped.
REQ-025 The arbiter SHALL introduce one IDLE cycle minimum between bursts (rlast beat cycle N, next master AR handshake no earlier than cycle N+1).
REQ-026 i_init_done falling mid-burst SHALL NOT abort the burst; it only blocks new grants.

Reset
REQ-027 While i_rst is high: state=IDLE, last_grant=1, counter=0, o_err=0, o_busy=0, o_grant=0.
REQ-028 While i_rst is high: o_s_arvalid=0, o_s_rready=0, all o_x_arready=0, all o_x_rvalid=0, and registered AR fields=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately (asynchronously); the slave is reset by the same system reset.

Verification
REQ-030 i_init_done=0, m0 arvalid for 10 cycles -> no arready, o_s_arvalid stays 0; raise init_done -> m0 arready same cycle, o_s_arvalid next cycle.
REQ-031 Both masters request continuously, len=3 each -> grants alternate m0,m1,m0,m1; each master receives exactly 4 beats with rlast on the 4th.
REQ-032 m1 granted, slave holds s_arready=0 for 5 cycles -> o_s_araddr and the other AR fields stable; m0 arready stays 0 throughout.
REQ-033 Granted master's rready toggled 1010..., len=7 -> s_rready mirrors it, 8 beats delivered in order, o_err=0.
REQ-034 Slave asserts rlast on beat 3 of len=7 -> o_err=1 sticky, return to IDLE, next grant proceeds normally.
REQ-035 i_rst pulsed in DATA at beat 2 -> all outputs go to reset values in the same cycle; after release, m0 wins the first tie.
